// File: rtl/of_action_applier_pkg.sv
// Shared definitions for the OpenFlow action applier.
//   - action_ctrl bit indices
//   - IOQ header ctrl code and destination-port field position
//   - register offsets of the statistics/status block
//   - main FSM state encoding
package of_action_applier_pkg;

    // action_ctrl = {drop, set_dl_src, set_dl_dst}
    localparam int ACT_SET_DL_DST = 0;
    localparam int ACT_SET_DL_SRC = 1;
    localparam int ACT_DROP       = 2;
    localparam int ACT_CTRL_WIDTH = 3;

    // IOQ module header: ctrl code and the dst-port bitmap field inside it
    localparam logic [7:0] IOQ_CTRL      = 8'hFF;
    localparam int         IOQ_DST_LO    = 48;
    localparam int         IOQ_DST_WIDTH = 16;

    // Register ring geometry
    localparam int UDP_REG_ADDR_WIDTH = 23;
    localparam int CPCI_DATA_WIDTH    = 32;

    localparam logic [1:0] REG_OFF_PKTS_FWD     = 2'd0;
    localparam logic [1:0] REG_OFF_PKTS_DROP    = 2'd1;
    localparam logic [1:0] REG_OFF_ACT_OVERFLOW = 2'd2;
    localparam logic [1:0] REG_OFF_ERR          = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_W1,
        ST_W2,
        ST_BODY,
        ST_DROP
    } state_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO.
//   din/wr_en     : write port; a write while full is discarded
//   dout/rd_en    : head word is visible on dout whenever empty=0; rd_en pops it
//   full          : DEPTH words stored
//   nearly_full   : DEPTH-1 or more words stored
//   empty         : no words stored
// reset is asynchronous, active-low, and empties the FIFO.
module fallthrough_small_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_COUNT   = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [DEPTH_BITS:0] NEARLY_COUNT = FULL_COUNT - 1'b1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_reg;
    logic [DEPTH_BITS-1:0] rd_ptr_reg;
    logic [DEPTH_BITS:0]   count_reg;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full        = (count_reg == FULL_COUNT);
    assign nearly_full = (count_reg >= NEARLY_COUNT);
    assign empty       = (count_reg == '0);
    assign wr_ok       = wr_en && !full;
    assign rd_ok       = rd_en && !empty;

    // Head must be visible without a read cycle, so the read is asynchronous.
    assign dout = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/of_action_applier_regs.sv
// Statistics/status block and UDP register ring slave for of_action_applier.
//   pkt_fwd_inc / pkt_drop_inc : one-cycle pulses per forwarded / dropped packet
//   act_ovf_inc                : action write discarded (counts + sets ERR[0])
//   pkt_ovf_set                : packet word discarded (sets ERR[1])
//   reg_*_in / reg_*_out       : register ring, one cycle of latency
// Offsets from REG_BASE_ADDR: 0 pkts_fwd, 1 pkts_drop, 2 act_overflow, 3 ERR.
// A write to offset 3 clears ERR; a clear beats a same-cycle set.
module of_action_applier_regs
    import of_action_applier_pkg::*;
#(
    parameter int REG_BASE_ADDR     = 0,
    parameter int UDP_REG_SRC_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pkt_fwd_inc,
    input  logic                          pkt_drop_inc,
    input  logic                          act_ovf_inc,
    input  logic                          pkt_ovf_set,
    input  logic                          reg_req_in,
    input  logic                          reg_ack_in,
    input  logic                          reg_rd_wr_L_in,
    input  logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_in,
    input  logic [CPCI_DATA_WIDTH-1:0]    reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_in,
    output logic                          reg_req_out,
    output logic                          reg_ack_out,
    output logic                          reg_rd_wr_L_out,
    output logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_out,
    output logic [CPCI_DATA_WIDTH-1:0]    reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_out
);

    localparam logic [UDP_REG_ADDR_WIDTH-1:0] BASE = UDP_REG_ADDR_WIDTH'(REG_BASE_ADDR);

    logic [31:0]                   pkts_fwd_reg;
    logic [31:0]                   pkts_drop_reg;
    logic [31:0]                   act_overflow_reg;
    logic [1:0]                    err_reg;
    logic [UDP_REG_ADDR_WIDTH-1:0] offset;
    logic                          hit;
    logic                          err_clear;
    logic [31:0]                   rd_value;

    // Offset computed by subtraction so the base need not be 4-aligned.
    assign offset    = reg_addr_in - BASE;
    assign hit       = reg_req_in && !reg_ack_in &&
                       (offset[UDP_REG_ADDR_WIDTH-1:2] == '0);
    assign err_clear = hit && !reg_rd_wr_L_in && (offset[1:0] == REG_OFF_ERR);

    always_comb begin
        rd_value = '0;
        case (offset[1:0])
            REG_OFF_PKTS_FWD:     rd_value = pkts_fwd_reg;
            REG_OFF_PKTS_DROP:    rd_value = pkts_drop_reg;
            REG_OFF_ACT_OVERFLOW: rd_value = act_overflow_reg;
            default:              rd_value = {30'd0, err_reg};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkts_fwd_reg     <= '0;
            pkts_drop_reg    <= '0;
            act_overflow_reg <= '0;
            err_reg          <= '0;
        end else begin
            if (pkt_fwd_inc)  pkts_fwd_reg     <= pkts_fwd_reg + 32'd1;
            if (pkt_drop_inc) pkts_drop_reg    <= pkts_drop_reg + 32'd1;
            if (act_ovf_inc)  act_overflow_reg <= act_overflow_reg + 32'd1;
            if (err_clear) begin
                err_reg <= '0;
            end else begin
                err_reg <= err_reg | {pkt_ovf_set, act_ovf_inc};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
        end else begin
            reg_req_out     <= reg_req_in;
            reg_ack_out     <= reg_ack_in | hit;
            reg_rd_wr_L_out <= reg_rd_wr_L_in;
            reg_addr_out    <= reg_addr_in;
            reg_data_out    <= (hit && reg_rd_wr_L_in) ? rd_value : reg_data_in;
            reg_src_out     <= reg_src_in;
        end
    end

endmodule

// File: rtl/of_action_applier.sv
// Applies matcher action records to buffered packets.
//   in_data/in_ctrl/in_wr/in_rdy     : packet words from the matcher
//   action_data/ctrl/valid/rdy       : one action record per packet
//                                      data = {dst_bitmap, new_dl_dst, new_dl_src}
//                                      ctrl = {drop, set_dl_src, set_dl_dst}
//   out_data/out_ctrl/out_wr/out_rdy : registered packet words to the output queues
//   reg_*_in / reg_*_out             : UDP register ring (see of_action_applier_regs)
// reset is asynchronous, active-low. MAC rewrite offsets assume DATA_WIDTH=64.
module of_action_applier
    import of_action_applier_pkg::*;
#(
    parameter int DATA_WIDTH          = 64,
    parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
    parameter int NUM_OUTPUT_QUEUES   = 8,
    parameter int PKT_FIFO_DEPTH_BITS = 3,
    parameter int ACT_FIFO_DEPTH_BITS = 2,
    parameter int REG_BASE_ADDR       = 0,
    parameter int UDP_REG_SRC_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [CTRL_WIDTH-1:0]         in_ctrl,
    input  logic                          in_wr,
    output logic                          in_rdy,
    input  logic [NUM_OUTPUT_QUEUES+95:0] action_data,
    input  logic [ACT_CTRL_WIDTH-1:0]     action_ctrl,
    input  logic                          action_valid,
    output logic                          action_rdy,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [CTRL_WIDTH-1:0]         out_ctrl,
    output logic                          out_wr,
    input  logic                          out_rdy,
    input  logic                          reg_req_in,
    input  logic                          reg_ack_in,
    input  logic                          reg_rd_wr_L_in,
    input  logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_in,
    input  logic [CPCI_DATA_WIDTH-1:0]    reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_in,
    output logic                          reg_req_out,
    output logic                          reg_ack_out,
    output logic                          reg_rd_wr_L_out,
    output logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_out,
    output logic [CPCI_DATA_WIDTH-1:0]    reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_out
);

    localparam int PKT_WIDTH = CTRL_WIDTH + DATA_WIDTH;
    localparam int ACT_WIDTH = ACT_CTRL_WIDTH + NUM_OUTPUT_QUEUES + 96;

    // FIFO interfaces
    logic [PKT_WIDTH-1:0] pkt_dout;
    logic                 pkt_full, pkt_nearly_full, pkt_empty, pkt_rd;
    logic [ACT_WIDTH-1:0] act_dout;
    logic                 act_full, act_nearly_full, act_empty, act_rd;

    // Head word and head action fields
    logic [CTRL_WIDTH-1:0]        head_ctrl;
    logic [DATA_WIDTH-1:0]        head_data;
    logic                         head_is_data;
    logic [ACT_CTRL_WIDTH-1:0]    act_ctrl;
    logic [NUM_OUTPUT_QUEUES-1:0] act_bitmap;
    logic [47:0]                  act_dst;
    logic [47:0]                  act_src;
    logic [IOQ_DST_WIDTH-1:0]     dst_field;

    // FSM and datapath
    state_t                state_reg, state_next;
    logic                  seen_data_reg, seen_data_next;
    logic                  emit, fwd_ok;
    logic                  fwd_inc, drop_inc;
    logic [DATA_WIDTH-1:0] word_next;
    logic                  out_wr_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [CTRL_WIDTH-1:0] out_ctrl_reg;

    fallthrough_small_fifo #(
        .WIDTH      (PKT_WIDTH),
        .DEPTH_BITS (PKT_FIFO_DEPTH_BITS)
    ) u_pkt_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (pkt_rd),
        .dout        (pkt_dout),
        .full        (pkt_full),
        .nearly_full (pkt_nearly_full),
        .empty       (pkt_empty)
    );

    fallthrough_small_fifo #(
        .WIDTH      (ACT_WIDTH),
        .DEPTH_BITS (ACT_FIFO_DEPTH_BITS)
    ) u_act_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({action_ctrl, action_data}),
        .wr_en       (action_valid),
        .rd_en       (act_rd),
        .dout        (act_dout),
        .full        (act_full),
        .nearly_full (act_nearly_full),
        .empty       (act_empty)
    );

    assign in_rdy     = !pkt_nearly_full;
    assign action_rdy = !act_nearly_full;

    assign {head_ctrl, head_data} = pkt_dout;
    assign head_is_data = (head_ctrl == '0);
    assign act_ctrl     = act_dout[ACT_WIDTH-1 -: ACT_CTRL_WIDTH];
    assign act_bitmap   = act_dout[NUM_OUTPUT_QUEUES+95:96];
    assign act_dst      = act_dout[95:48];
    assign act_src      = act_dout[47:0];
    assign dst_field    = IOQ_DST_WIDTH'(act_bitmap);
    assign fwd_ok       = !pkt_empty && out_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            seen_data_reg <= 1'b0;
            out_wr_reg    <= 1'b0;
            out_data_reg  <= '0;
            out_ctrl_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            seen_data_reg <= seen_data_next;
            out_wr_reg    <= emit;
            if (emit) begin
                out_data_reg <= word_next;
                out_ctrl_reg <= head_ctrl;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        seen_data_next = seen_data_reg;
        pkt_rd         = 1'b0;
        act_rd         = 1'b0;
        emit           = 1'b0;
        fwd_inc        = 1'b0;
        drop_inc       = 1'b0;
        word_next      = head_data;
        case (state_reg)
            ST_IDLE: begin
                seen_data_next = 1'b0;
                if (!pkt_empty && !act_empty) begin
                    state_next = act_ctrl[ACT_DROP] ? ST_DROP : ST_HDR;
                end
            end
            ST_HDR: begin
                if (!pkt_empty) begin
                    // First data word is left in the FIFO so W1 handles it.
                    if (head_is_data) begin
                        state_next = ST_W1;
                    end else if (out_rdy) begin
                        pkt_rd = 1'b1;
                        emit   = 1'b1;
                        if (head_ctrl == IOQ_CTRL) begin
                            word_next[IOQ_DST_LO +: IOQ_DST_WIDTH] = dst_field;
                        end
                    end
                end
            end
            ST_W1: begin
                if (fwd_ok) begin
                    pkt_rd     = 1'b1;
                    emit       = 1'b1;
                    state_next = ST_W2;
                    if (act_ctrl[ACT_SET_DL_DST]) word_next[63:16] = act_dst;
                    if (act_ctrl[ACT_SET_DL_SRC]) word_next[15:0]  = act_src[47:32];
                end
            end
            ST_W2: begin
                if (fwd_ok) begin
                    pkt_rd = 1'b1;
                    emit   = 1'b1;
                    if (act_ctrl[ACT_SET_DL_SRC]) word_next[63:32] = act_src[31:0];
                    // W1 was data, so a ctrl!=0 word here is already the EOP.
                    if (head_is_data) begin
                        state_next = ST_BODY;
                    end else begin
                        act_rd     = 1'b1;
                        fwd_inc    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_BODY: begin
                if (fwd_ok) begin
                    pkt_rd = 1'b1;
                    emit   = 1'b1;
                    if (!head_is_data) begin
                        act_rd     = 1'b1;
                        fwd_inc    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                // Dropped words never reach the output, so out_rdy is ignored.
                if (!pkt_empty) begin
                    pkt_rd = 1'b1;
                    if (head_is_data) begin
                        seen_data_next = 1'b1;
                    end else if (seen_data_reg) begin
                        act_rd     = 1'b1;
                        drop_inc   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign out_wr   = out_wr_reg;
    assign out_data = out_data_reg;
    assign out_ctrl = out_ctrl_reg;

    of_action_applier_regs #(
        .REG_BASE_ADDR     (REG_BASE_ADDR),
        .UDP_REG_SRC_WIDTH (UDP_REG_SRC_WIDTH)
    ) u_regs (
        .clk             (clk),
        .reset           (reset),
        .pkt_fwd_inc     (fwd_inc),
        .pkt_drop_inc    (drop_inc),
        .act_ovf_inc     (action_valid && act_full),
        .pkt_ovf_set     (in_wr && pkt_full),
        .reg_req_in      (reg_req_in),
        .reg_ack_in      (reg_ack_in),
        .reg_rd_wr_L_in  (reg_rd_wr_L_in),
        .reg_addr_in     (reg_addr_in),
        .reg_data_in     (reg_data_in),
        .reg_src_in      (reg_src_in),
        .reg_req_out     (reg_req_out),
        .reg_ack_out     (reg_ack_out),
        .reg_rd_wr_L_out (reg_rd_wr_L_out),
        .reg_addr_out    (reg_addr_out),
        .reg_data_out    (reg_data_out),
        .reg_src_out     (reg_src_out)
    );

endmodule
